// File: rtl/counter_sweep_ctrl.sv
// Triangle-wave sequencer: sweeps Q between latched limits with dwell at
// each end, for a fixed number of sweeps or continuously.
module counter_sweep_ctrl #(
    parameter int bits       = 4,
    parameter int dwell_bits = 4,
    parameter int sweep_bits = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [bits-1:0]       lo_lim,
    input  logic [bits-1:0]       hi_lim,
    input  logic [dwell_bits-1:0] dwell,
    input  logic [sweep_bits-1:0] sweeps,
    output logic [bits-1:0]       Q,
    output logic                  dir,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        IDLE,
        UP,
        HOLD_HI,
        DOWN,
        HOLD_LO
    } state_t;

    localparam logic [bits-1:0]       QONE = 1;
    localparam logic [dwell_bits-1:0] DONE = 1;
    localparam logic [sweep_bits-1:0] SONE = 1;

    state_t                state_q, state_d;
    logic [bits-1:0]       q_q, q_d;
    logic [bits-1:0]       lo_q, lo_d;
    logic [bits-1:0]       hi_q, hi_d;
    logic [dwell_bits-1:0] dw_q, dw_d;
    logic [dwell_bits-1:0] dcnt_q, dcnt_d;
    logic [sweep_bits-1:0] sw_q, sw_d;
    logic [sweep_bits-1:0] scnt_q, scnt_d;
    logic [sweep_bits-1:0] scnt_inc;
    logic                  dir_q, dir_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    assign scnt_inc = scnt_q + SONE;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        dw_d    = dw_q;
        sw_d    = sw_q;
        dcnt_d  = dcnt_q;
        scnt_d  = scnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if (lo_lim < hi_lim) begin
                        lo_d    = lo_lim;
                        hi_d    = hi_lim;
                        dw_d    = dwell;
                        sw_d    = sweeps;
                        q_d     = lo_lim;
                        scnt_d  = '0;
                        state_d = UP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            UP: begin
                if (q_q != hi_q) begin
                    q_d = q_q + QONE;
                end else if (dw_q != '0) begin
                    dcnt_d  = dw_q - DONE;
                    state_d = HOLD_HI;
                end else begin
                    q_d     = q_q - QONE;
                    state_d = DOWN;
                end
            end
            HOLD_HI: begin
                if (dcnt_q == '0) begin
                    q_d     = q_q - QONE;
                    state_d = DOWN;
                end else begin
                    dcnt_d = dcnt_q - DONE;
                end
            end
            DOWN: begin
                if (q_q != lo_q) begin
                    q_d = q_q - QONE;
                end else begin
                    scnt_d = scnt_inc;
                    if (sw_q != '0 && scnt_inc == sw_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (dw_q != '0) begin
                        dcnt_d  = dw_q - DONE;
                        state_d = HOLD_LO;
                    end else begin
                        q_d     = q_q + QONE;
                        state_d = UP;
                    end
                end
            end
            HOLD_LO: begin
                if (dcnt_q == '0) begin
                    q_d     = q_q + QONE;
                    state_d = UP;
                end else begin
                    dcnt_d = dcnt_q - DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort freezes Q where it is and suppresses any completion pulse.
        if (state_q != IDLE && abort) begin
            state_d = IDLE;
            q_d     = q_q;
            done_d  = 1'b0;
        end
        dir_d  = (state_d == UP) || (state_d == HOLD_HI);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            dw_q    <= '0;
            sw_q    <= '0;
            dcnt_q  <= '0;
            scnt_q  <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            dw_q    <= dw_d;
            sw_q    <= sw_d;
            dcnt_q  <= dcnt_d;
            scnt_q  <= scnt_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign Q    = q_q;
    assign dir  = dir_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule
